// File: rtl/mem_stage_pkg.sv
// Shared types and default sizing for the MEM pipeline stage in front of the 128x8 data RAM.
package mem_stage_pkg;

    localparam int MEM_ADDR_W = 7;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_TAG_W  = 4;

    localparam logic [MEM_DATA_W-1:0] MEM_INIT_VAL = 8'h00;

    typedef enum logic [1:0] {
        INIT,
        EMPTY,
        FULL
    } mem_state_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] data;
        logic [MEM_TAG_W-1:0]  rd;
        logic                  load;
    } mem_result_t;

endpackage

// File: rtl/mem_init_sweep.sv
// Post-reset RAM clear: walks every address once, one write per cycle, then raises done.
module mem_init_sweep
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic              last_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] count_q;
    logic              done_q;

    assign addr_o = count_q;
    assign we_o   = ~done_q;
    assign done_o = done_q;
    assign last_o = ~done_q && (count_q == {ADDR_W{1'b1}});

    // Counter freezes in meaning once done is set; its value is no longer observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (!done_q) begin
            count_q <= count_q + 1'b1;
            if (last_o) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: zero-fills the data RAM after reset, then runs load/store ops with a one-entry result register.
// Optional load/store counters are enabled with `define MEM_ACCESS_CNT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int                ADDR_W   = MEM_ADDR_W,
    parameter int                DATA_W   = MEM_DATA_W,
    parameter int                TAG_W    = MEM_TAG_W,
    parameter logic [DATA_W-1:0] INIT_VAL = MEM_INIT_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [TAG_W-1:0]  in_rd,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_rd,
    output logic              out_load,
    output logic              init_done
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt
`endif
);

    mem_state_t        state_q;
    mem_result_t       res_q;
    mem_result_t       res_d;
    logic [ADDR_W-1:0] sweepAddr;
    logic              sweepWe;
    logic              sweepLast;
    logic              sweepDone;
    logic              accept;

    mem_init_sweep #(
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk    (clk),
        .rst    (rst),
        .addr_o (sweepAddr),
        .we_o   (sweepWe),
        .last_o (sweepLast),
        .done_o (sweepDone)
    );

    // No skid buffer: a full result register only frees up in the cycle WB takes it.
    assign in_ready = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        ram_en   = accept & in_we;
        ram_addr = in_addr;
        ram_data = in_wdata;
        if (state_q == INIT) begin
            ram_en   = sweepWe;
            ram_addr = sweepAddr;
            ram_data = INIT_VAL;
        end
    end

    always_comb begin
        res_d      = '0;
        res_d.data = in_we ? in_wdata : ram_out;
        res_d.rd   = in_rd;
        res_d.load = ~in_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            res_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (sweepLast) begin
                        state_q <= EMPTY;
                    end
                end
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        res_q   <= res_d;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (accept) begin
                            res_q <= res_d;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = res_q.data;
    assign out_rd    = res_q.rd;
    assign out_load  = res_q.load;
    assign init_done = sweepDone;

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] load_cnt_q;
    logic [15:0] store_cnt_q;

    // Sweep writes never count: accept is held low throughout INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else if (accept) begin
            if (in_we && (store_cnt_q != 16'hFFFF)) begin
                store_cnt_q <= store_cnt_q + 16'd1;
            end
            if (!in_we && (load_cnt_q != 16'hFFFF)) begin
                load_cnt_q <= load_cnt_q + 16'd1;
            end
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: random and directed load/store traffic against a behavioural RAM model.
module tb_mem_access_stage;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] rd;
        logic       load;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_we;
    logic [6:0] in_addr;
    logic [7:0] in_wdata;
    logic [3:0] in_rd;
    logic [7:0] ram_data;
    logic [6:0] ram_addr;
    logic       ram_en;
    logic [7:0] ram_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_rd;
    logic       out_load;
    logic       init_done;
`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;
    int          tbLoads;
    int          tbStores;
`endif

    int   checks = 0;
    int   errors = 0;
    int   rdyMode = 1;
    exp_t expQ[$];
    logic [7:0] refMem [0:127];
    logic [7:0] ramArr [0:127];

    logic       prevStalled = 1'b0;
    logic [7:0] prevData;
    logic [3:0] prevRd;
    logic       prevLoad;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_we     (in_we),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_rd     (in_rd),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_out   (ram_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_load  (out_load),
        .init_done (init_done)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt)
`endif
    );

    // Physical RAM attached to the stage; starts with garbage so the zero fill is observable.
    assign ram_out = ramArr[ram_addr];
    always @(posedge clk) begin
        if (ram_en) ramArr[ram_addr] <= ram_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveReady();
        if (rdyMode == 2) out_ready = 1'($urandom_range(0, 1));
        else              out_ready = (rdyMode == 1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            driveReady();
        end
    endtask

    // Offers one op until accepted; the expected result is derived from the reference RAM contents.
    task automatic applyStimulus(input logic we, input logic [6:0] addr, input logic [7:0] data, input logic [3:0] rd);
        bit accepted = 0;
        exp_t e;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_we    = we;
            in_addr  = addr;
            in_wdata = data;
            in_rd    = rd;
            driveReady();
            #1;
            if (in_ready) begin
                accepted = 1;
                e.rd   = rd;
                e.load = ~we;
                if (we) begin
                    e.data       = data;
                    refMem[addr] = data;
                end else begin
                    e.data = refMem[addr];
                end
                expQ.push_back(e);
`ifdef MEM_ACCESS_CNT_EN
                if (we) tbStores++;
                else    tbLoads++;
`endif
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: op addr 0x%0h never accepted, expected acceptance within 50 cycles", addr);
        end
    endtask

    // Called at the negedge where rst has just dropped; checks the full 128-cycle sweep.
    task automatic checkSweep();
        for (int i = 0; i < 128; i++) begin
            #3;
            checkOutput("sweep_ram_en", 32'(ram_en), 32'd1);
            checkOutput("sweep_ram_addr", 32'(ram_addr), 32'(i));
            checkOutput("sweep_ram_data", 32'(ram_data), 32'h00);
            checkOutput("sweep_in_ready", 32'(in_ready), 32'd0);
            checkOutput("sweep_init_done_low", 32'(init_done), 32'd0);
            @(negedge clk);
            in_valid = (i % 3 == 0);
        end
        #3;
        checkOutput("sweep_init_done_high", 32'(init_done), 32'd1);
        for (int i = 0; i < 128; i++) refMem[i] = 8'h00;
    endtask

    // Monitor: checks handshake rules and pops the scoreboard on every WB transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst || !init_done) begin
                prevStalled = 1'b0;
            end else begin
                checkOutput("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
                checkOutput("ram_en_rule", 32'(ram_en), 32'(in_valid && in_ready && in_we));
                checkOutput("ram_addr_pass", 32'(ram_addr), 32'(in_addr));
                if (prevStalled) begin
                    checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall_out_data", 32'(out_data), 32'(prevData));
                    checkOutput("stall_out_rd", 32'(out_rd), 32'(prevRd));
                    checkOutput("stall_out_load", 32'(out_load), 32'(prevLoad));
                end
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_result: got data 0x%0h rd %0d, expected no result", out_data, out_rd);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("out_data", 32'(out_data), 32'(e.data));
                        checkOutput("out_rd", 32'(out_rd), 32'(e.rd));
                        checkOutput("out_load", 32'(out_load), 32'(e.load));
                    end
                end
                prevStalled = out_valid && !out_ready;
                prevData    = out_data;
                prevRd      = out_rd;
                prevLoad    = out_load;
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            ramArr[i] <= 8'($urandom_range(1, 255));
            refMem[i] = 8'h00;
        end
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_we     = 1'b0;
        in_addr   = '0;
        in_wdata  = '0;
        in_rd     = '0;
        out_ready = 1'b0;
`ifdef MEM_ACCESS_CNT_EN
        tbLoads  = 0;
        tbStores = 0;
`endif

        repeat (3) @(negedge clk);
        #3;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_out_rd", 32'(out_rd), 32'd0);
        checkOutput("reset_out_load", 32'(out_load), 32'd0);
        checkOutput("reset_init_done", 32'(init_done), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkSweep();

        // Store then load to the same address back-to-back, then a never-written address.
        rdyMode = 1;
        applyStimulus(1'b1, 7'h12, 8'hA5, 4'd5);
        applyStimulus(1'b0, 7'h12, 8'h00, 4'd3);
        applyStimulus(1'b0, 7'h40, 8'h00, 4'd7);
        idleCycles(2);

        // Hold WB off for five cycles with a pending op, then release both at once.
        rdyMode = 0;
        applyStimulus(1'b1, 7'h20, 8'h3C, 4'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_we     = 1'b0;
            in_addr   = 7'h20;
            in_rd     = 4'd2;
            out_ready = 1'b0;
            #1;
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_ram_en", 32'(ram_en), 32'd0);
        end
        rdyMode = 1;
        applyStimulus(1'b0, 7'h20, 8'h00, 4'd2);
        idleCycles(2);

        // Random traffic on a small address window so loads hit recent stores.
        rdyMode = 2;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                          8'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)));
        end
        rdyMode = 1;
        idleCycles(4);
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);

        // Reset while a result is parked in FULL.
        rdyMode = 0;
        applyStimulus(1'b0, 7'h05, 8'h00, 4'd4);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_init_done", 32'(init_done), 32'd0);
        checkOutput("midrst_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("midrst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef MEM_ACCESS_CNT_EN
        tbLoads  = 0;
        tbStores = 0;
`endif
        checkSweep();

        rdyMode = 1;
        applyStimulus(1'b0, 7'h12, 8'h00, 4'd9);
        applyStimulus(1'b1, 7'h01, 8'h11, 4'd1);
        applyStimulus(1'b1, 7'h02, 8'h22, 4'd2);
        applyStimulus(1'b1, 7'h03, 8'h33, 4'd3);
        applyStimulus(1'b0, 7'h02, 8'h00, 4'd6);
        idleCycles(2);
`ifdef MEM_ACCESS_CNT_EN
        #3;
        checkOutput("store_cnt", 32'(store_cnt), 32'(tbStores));
        checkOutput("load_cnt", 32'(load_cnt), 32'(tbLoads));
        checkOutput("store_cnt_three", 32'(store_cnt), 32'd3);
        checkOutput("load_cnt_two", 32'(load_cnt), 32'd2);
        @(negedge clk);
        force dut.store_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.store_cnt_q;
        applyStimulus(1'b1, 7'h04, 8'h44, 4'd4);
        idleCycles(2);
        #3;
        checkOutput("store_cnt_saturate", 32'(store_cnt), 32'hFFFF);
        checkOutput("load_cnt_after_sat", 32'(load_cnt), 32'd2);
`endif
        idleCycles(2);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
